// File: rtl/seq_parser_pkg.sv
// Shared types, header layout and helpers for the multi-stream sequence parser.
package seq_parser_pkg;

  localparam int HDR_BYTES = 8;

  // Byte offsets inside the 8-byte header; multi-byte fields are little-endian.
  localparam int OFF_LEN    = 0;
  localparam int OFF_STREAM = 2;
  localparam int OFF_SEQ    = 4;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAY,
    COMMIT,
    DRAIN
  } parseState_t;

  typedef struct packed {
    logic        trunc;
    logic [15:0] stream;
    logic [31:0] seq;
    logic [15:0] length;
  } recHdr_t;

  // Byte 0 of a word travels on dataIn[31:24].
  function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/seq_tracker.sv
// Per-stream sequence table {valid, expected}; classifies a committed packet
// combinationally and records seq+1 only for accepted packets.
module seq_tracker #(
  parameter int NUM_STREAMS = 16
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic [$clog2(NUM_STREAMS)-1:0] streamIdx,
  input  logic [31:0]                    seq,
  input  logic                           commit,
  output logic                           accept,
  output logic                           gap,
  output logic [31:0]                    diff
);

  logic [NUM_STREAMS-1:0] entryValid;
  logic [31:0]            entryExp [NUM_STREAMS];
  logic                   entryHit;
  logic [31:0]            rawDiff;

  assign entryHit = entryValid[streamIdx];
  assign rawDiff  = seq - entryExp[streamIdx];

  // Half the sequence space ahead counts as a gap, the other half as stale.
  assign accept = !entryHit || !rawDiff[31];
  assign gap    = entryHit && !rawDiff[31] && (rawDiff != 32'd0);
  assign diff   = entryHit ? rawDiff : 32'd0;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      entryValid <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) entryExp[i] <= '0;
    end else if (commit && accept) begin
      entryValid[streamIdx] <= 1'b1;
      entryExp[streamIdx]   <= seq + 32'd1;
    end
  end

endmodule

// File: rtl/seq_stream_parser.sv
// Length-prefixed packet parser with per-stream sequence tracking, a one-deep
// record output register and lost/drop statistics.
//
// state  | meaning
// HDR0   | waiting for header word 0 (length, stream)
// HDR1   | waiting for header word 1 (sequence number)
// PAY    | collecting payload words
// COMMIT | classify against the tracker, load or drop the record
// DRAIN  | discarding a malformed packet up to its last word
module seq_stream_parser
  import seq_parser_pkg::*;
#(
  parameter int NUM_STREAMS   = 16,
  parameter int PAYLOAD_BYTES = 32,
  parameter int OUT_W         = 65 + 8*PAYLOAD_BYTES
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [31:0]      dataIn,
  input  logic             dataIn_val,
  output logic             dataIn_ready,
  input  logic             dataIN_last,
  output logic [OUT_W-1:0] dataOut,
  output logic             dataOut_val,
  input  logic             dataOut_ready,
  output logic             packetLost,
  output logic [31:0]      lostGap,
  output logic [31:0]      lostCount,
  output logic [15:0]      dropCount
);

  localparam int IDX_W = $clog2(NUM_STREAMS);
  localparam int PAY_W = 8*PAYLOAD_BYTES;

  parseState_t      state;
  logic             outOfReset;
  logic [15:0]      lenReg;
  logic [15:0]      streamReg;
  logic [31:0]      seqReg;
  logic [14:0]      remWords;
  logic [15:0]      byteIdx;
  logic [PAY_W-1:0] payReg;
  logic [PAY_W-1:0] payNext;

  logic [15:0] w0Len;
  logic [15:0] w0Stream;
  logic [16:0] w0Sum;
  logic [14:0] w0Words;
  logic [31:0] w1Seq;
  logic        w0Bad;
  logic        canLoad;
  logic        inAcc;
  logic        takeW0;
  logic        midWord;
  logic        lastExp;
  logic        w0Drop;
  logic        midDrop;
  logic        staleDrop;
  logic        commitNow;
  logic [1:0]  dropInc;
  logic [16:0] dropSum;
  logic [15:0] validBytes;
  logic        trkAccept;
  logic        trkGap;
  logic [31:0] trkDiff;
  recHdr_t     hdrNext;

  assign w0Len    = {wordByte(dataIn, 2'(OFF_LEN + 1)), wordByte(dataIn, 2'(OFF_LEN))};
  assign w0Stream = {wordByte(dataIn, 2'(OFF_STREAM + 1)), wordByte(dataIn, 2'(OFF_STREAM))};
  assign w1Seq    = {wordByte(dataIn, 2'(OFF_SEQ - 1)), wordByte(dataIn, 2'(OFF_SEQ - 2)),
                     wordByte(dataIn, 2'(OFF_SEQ - 3)), wordByte(dataIn, 2'(OFF_SEQ - 4))};
  assign w0Sum    = {1'b0, w0Len} + 17'd3;
  assign w0Words  = w0Sum[16:2];
  assign w0Bad    = (w0Len < 16'(HDR_BYTES)) || ({16'b0, w0Stream} >= 32'(NUM_STREAMS));

  // A stalled COMMIT blocks input; otherwise a word arriving in COMMIT is
  // already header word 0 of the next packet.
  assign canLoad      = !dataOut_val || dataOut_ready;
  assign dataIn_ready = outOfReset && !(state == COMMIT && !canLoad);
  assign inAcc        = dataIn_val && dataIn_ready;
  assign takeW0       = inAcc && (state == HDR0 || state == COMMIT);
  assign midWord      = inAcc && (state == HDR1 || state == PAY);
  assign lastExp      = (remWords == 15'd1);
  assign commitNow    = (state == COMMIT) && canLoad;

  assign w0Drop    = takeW0 && (dataIN_last || w0Bad);
  assign midDrop   = midWord && (dataIN_last != lastExp);
  assign staleDrop = commitNow && !trkAccept;
  assign dropInc   = {1'b0, w0Drop} + {1'b0, midDrop} + {1'b0, staleDrop};
  assign dropSum   = {1'b0, dropCount} + {15'b0, dropInc};

  assign validBytes = lenReg - 16'(HDR_BYTES);

  always_comb begin
    hdrNext.trunc  = (validBytes > 16'(PAYLOAD_BYTES));
    hdrNext.stream = streamReg;
    hdrNext.seq    = seqReg;
    hdrNext.length = lenReg;
  end

  // Bytes past the declared length (final-word padding) or past the record
  // capacity are never written, so they stay zero from the word-0 clear.
  always_comb begin
    payNext = payReg;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (16'(k) >= byteIdx && 16'(k) < byteIdx + 16'd4 && 16'(k) < validBytes)
        payNext[(PAYLOAD_BYTES-1-k)*8 +: 8] = wordByte(dataIn, 2'(16'(k) - byteIdx));
    end
  end

  seq_tracker #(
    .NUM_STREAMS(NUM_STREAMS)
  ) u_tracker (
    .clk      (clk),
    .reset_b  (reset_b),
    .streamIdx(streamReg[IDX_W-1:0]),
    .seq      (seqReg),
    .commit   (commitNow),
    .accept   (trkAccept),
    .gap      (trkGap),
    .diff     (trkDiff)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= HDR0;
      outOfReset  <= 1'b0;
      lenReg      <= '0;
      streamReg   <= '0;
      seqReg      <= '0;
      remWords    <= '0;
      byteIdx     <= '0;
      payReg      <= '0;
      dataOut     <= '0;
      dataOut_val <= 1'b0;
      packetLost  <= 1'b0;
      lostGap     <= '0;
      lostCount   <= '0;
      dropCount   <= '0;
    end else begin
      outOfReset <= 1'b1;
      packetLost <= 1'b0;
      if (dataOut_val && dataOut_ready) dataOut_val <= 1'b0;
      if (dropInc != 2'd0) dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];

      if (commitNow && trkAccept) begin
        dataOut     <= {hdrNext, payReg};
        dataOut_val <= 1'b1;
        if (trkGap) begin
          packetLost <= 1'b1;
          lostGap    <= trkDiff;
          lostCount  <= satAdd32(lostCount, trkDiff);
        end
      end

      if (takeW0) begin
        lenReg    <= w0Len;
        streamReg <= w0Stream;
        remWords  <= w0Words - 15'd1;
        byteIdx   <= '0;
        payReg    <= '0;
      end

      case (state)
        HDR0, COMMIT: begin
          if (takeW0) state <= w0Drop ? (dataIN_last ? HDR0 : DRAIN) : HDR1;
          else if (commitNow) state <= HDR0;
        end
        HDR1, PAY: begin
          if (midWord) begin
            remWords <= remWords - 15'd1;
            if (state == HDR1) begin
              seqReg <= w1Seq;
            end else begin
              payReg  <= payNext;
              byteIdx <= byteIdx + 16'd4;
            end
            if (dataIN_last) state <= lastExp ? COMMIT : HDR0;
            else             state <= lastExp ? DRAIN : PAY;
          end
        end
        DRAIN: begin
          if (inAcc && dataIN_last) state <= HDR0;
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_parser.sv
// Scoreboard bench for seq_stream_parser: a reference sequence table predicts
// each record, loss pulse and drop, and a monitor compares DUT output in order.
module tb_seq_stream_parser;

  localparam int NS = 16;
  localparam int PB = 32;
  localparam int OW = 65 + 8*PB;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [31:0]   dataIn;
  logic          dataIn_val;
  logic          dataIn_ready;
  logic          dataIN_last;
  logic [OW-1:0] dataOut;
  logic          dataOut_val;
  logic          dataOut_ready;
  logic          packetLost;
  logic [31:0]   lostGap;
  logic [31:0]   lostCount;
  logic [15:0]   dropCount;

  seq_stream_parser #(
    .NUM_STREAMS  (NS),
    .PAYLOAD_BYTES(PB)
  ) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .dataIn       (dataIn),
    .dataIn_val   (dataIn_val),
    .dataIn_ready (dataIn_ready),
    .dataIN_last  (dataIN_last),
    .dataOut      (dataOut),
    .dataOut_val  (dataOut_val),
    .dataOut_ready(dataOut_ready),
    .packetLost   (packetLost),
    .lostGap      (lostGap),
    .lostCount    (lostCount),
    .dropCount    (dropCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] rec;
    logic          lost;
    logic [31:0]   gap;
  } sbEntry_t;

  sbEntry_t    sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        tv [NS];
  logic [31:0] te [NS];
  logic [31:0] expLost = 32'd0;
  int          expDrop = 0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int s, input logic [31:0] sq, input int k);
    return 8'(k*13 + s*5) ^ sq[7:0];
  endfunction

  function automatic logic [OW-1:0] mkRec(input int s, input logic [31:0] sq, input int len);
    logic [8*PB-1:0] pay;
    int nb;
    pay = '0;
    nb  = len - 8;
    for (int k = 0; k < PB; k++)
      if (k < nb) pay[(PB-1-k)*8 +: 8] = pbyte(s, sq, k);
    return {(nb > PB) ? 1'b1 : 1'b0, 16'(s), sq, 16'(len), pay};
  endfunction

  task automatic waitAccept();
    int t = 0;
    @(negedge clk);
    while (!dataIn_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!dataIn_ready) chk("in_timeout", dataIn_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // lastAt < 0 puts last on the word implied by the length field.
  task automatic sendPkt(input int s, input logic [31:0] sq, input int len, input int lastAt = -1);
    int nw, la, k;
    logic [15:0] l16, s16;
    logic [31:0] word, d;
    sbEntry_t e;
    nw  = (len + 3) / 4;
    la  = (lastAt < 0) ? nw - 1 : lastAt;
    l16 = 16'(len);
    s16 = 16'(s);
    e.rec  = mkRec(s, sq, len);
    e.lost = 1'b0;
    e.gap  = 32'd0;
    if (la != nw - 1 || len < 8 || s >= NS) begin
      expDrop++;
    end else if (!tv[s]) begin
      tv[s] = 1'b1;
      te[s] = sq + 32'd1;
      sb.push_back(e);
    end else begin
      d = sq - te[s];
      if (d[31]) begin
        expDrop++;
      end else begin
        if (d != 32'd0) begin
          e.lost  = 1'b1;
          e.gap   = d;
          expLost = ({1'b0, expLost} + {1'b0, d} > 33'hFFFF_FFFF) ? 32'hFFFF_FFFF : expLost + d;
        end
        te[s] = sq + 32'd1;
        sb.push_back(e);
      end
    end
    for (int w = 0; w <= la; w++) begin
      if (w == 0) word = {l16[7:0], l16[15:8], s16[7:0], s16[15:8]};
      else if (w == 1) word = {sq[7:0], sq[15:8], sq[23:16], sq[31:24]};
      else begin
        for (int b = 0; b < 4; b++) begin
          k = (w - 2)*4 + b;
          word[31-8*b -: 8] = (k < len - 8) ? pbyte(s, sq, k) : 8'hEE;
        end
      end
      dataIn      = word;
      dataIn_val  = 1'b1;
      dataIN_last = (w == la);
      waitAccept();
    end
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    repeat (3) @(posedge clk);
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("sb_drain", sb.size(), 0);
    chk("drop_cnt", dropCount, 16'(expDrop));
    chk("lost_cnt", lostCount, expLost);
  endtask

  logic prevVal = 1'b0;
  logic prevHs = 1'b0;
  logic newRec;

  always @(negedge clk) begin
    if (!reset_b) begin
      prevVal = 1'b0;
      prevHs  = 1'b0;
    end else begin
      newRec = dataOut_val && (!prevVal || prevHs);
      if (dataOut_val) begin
        if (sb.size() == 0) begin
          chk("unexpected_rec", dataOut_val, 0);
        end else begin
          chk("rec", dataOut, sb[0].rec);
          if (newRec) begin
            chk("lost_pulse", packetLost, sb[0].lost);
            if (sb[0].lost) chk("lost_gap", lostGap, sb[0].gap);
          end
          if (dataOut_ready) void'(sb.pop_front());
        end
      end
      if (packetLost && !newRec) chk("stray_pulse", packetLost, 0);
      prevVal = dataOut_val;
      prevHs  = dataOut_val && dataOut_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      tv[i] = 1'b0;
      te[i] = 32'd0;
    end
    reset_b       = 1'b0;
    dataIn        = 32'd0;
    dataIn_val    = 1'b0;
    dataIN_last   = 1'b0;
    dataOut_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", dataIn_ready, 0);
    chk("rst_out_val", dataOut_val, 0);
    chk("rst_out", dataOut, 0);
    chk("rst_lost", packetLost, 0);
    chk("rst_gap", lostGap, 0);
    chk("rst_lost_cnt", lostCount, 0);
    chk("rst_drop_cnt", dropCount, 0);
    @(posedge clk);
    #1 reset_b = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", dataIn_ready, 1);

    // in-order pair, gap on the third, then empty-payload and truncated records
    sendPkt(12, 32'd1, 20);
    sendPkt(13, 32'd1, 25);
    sendPkt(12, 32'd3, 39);
    settle();
    sendPkt(14, 32'd7, 8);
    sendPkt(15, 32'd100, 50);
    settle();

    // duplicate is dropped and leaves the table at expected = 11
    sendPkt(5, 32'd10, 20);
    sendPkt(5, 32'd10, 20);
    settle();
    sendPkt(5, 32'd11, 16);
    settle();

    // out-of-range stream drains without back-pressure
    sendPkt(20, 32'd1, 16);
    settle();
    chk("rdy_after_drop", dataIn_ready, 1);

    // malformed framing: early last, last on word 0, short length, late last
    sendPkt(6, 32'd1, 20, 3);
    sendPkt(6, 32'd2, 24);
    sendPkt(7, 32'd1, 20, 0);
    sendPkt(7, 32'd1, 6);
    sendPkt(7, 32'd1, 12, 4);
    sendPkt(7, 32'd1, 12);
    settle();

    // consumer stall across two queued packets
    dataOut_ready = 1'b0;
    sendPkt(8, 32'd1, 16);
    sendPkt(9, 32'd1, 20);
    @(negedge clk);
    chk("stall_in_ready", dataIn_ready, 0);
    chk("stall_out_val", dataOut_val, 1);
    repeat (6) @(negedge clk);
    chk("stall_in_ready_hold", dataIn_ready, 0);
    @(posedge clk);
    #1 dataOut_ready = 1'b1;
    settle();

    // sequence wrap, stale far-ahead value, then a gap of 15
    sendPkt(1, 32'hFFFF_FFFF, 12);
    sendPkt(1, 32'h0000_0000, 12);
    settle();
    sendPkt(1, 32'h8000_0001, 12);
    sendPkt(1, 32'h0000_0010, 12);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
